map_memory: RTL

MAP_MEMORY -- requirements
Module: map_memory

---
 rtl/map_memory.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/map_memory.sv
`default_nettype none
// ============================================================================
//  Module      : map_memory
//  Description : Wall map for a tile-based game. Holds a GAME_HEIGHT x WIDTH
//                bit grid (1 = wall), loads a bordered default map after
//                reset or i_clear, and serves two independent registered
//                read ports: display and game-logic collision query.
//                Game writes go through a small FIFO that is only drained
//                while the display generator is idle (i_buzy = 0).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                   clock (rising edge), async active-high reset
//    i_buzy                     display active; blocks draining of the FIFO
//    i_request_x/y -> o_is_wall       display read, 1-cycle latency
//    i_query_x/y   -> o_query_wall    game read, 1-cycle latency
//    i_wr_valid/x/y/wall, o_wr_ready  game write request (valid/ready)
//    i_clear                    pulse: reload default map, flush FIFO
//    o_init_done                map valid and accepting writes
// ============================================================================
module map_memory #(
  parameter int WIDTH       = 64,
  parameter int GAME_HEIGHT = 44,
  parameter int WQ_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_buzy,
  input  logic [5:0] i_request_x,
  input  logic [5:0] i_request_y,
  output logic       o_is_wall,
  input  logic [5:0] i_query_x,
  input  logic [5:0] i_query_y,
  output logic       o_query_wall,
  input  logic       i_wr_valid,
  input  logic [5:0] i_wr_x,
  input  logic [5:0] i_wr_y,
  input  logic       i_wr_wall,
  output logic       o_wr_ready,
  input  logic       i_clear,
  output logic       o_init_done
);

  localparam int ROW_W = $clog2(GAME_HEIGHT);
  localparam int COL_W = $clog2(WIDTH);
  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Coordinates arrive as 6-bit values; compare them in 7 bits so that a
  // grid dimension of exactly 64 is still representable as a limit.
  localparam logic [6:0]       ROW_LIMIT  = 7'(GAME_HEIGHT);
  localparam logic [6:0]       COL_LIMIT  = 7'(WIDTH);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(GAME_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(WQ_DEPTH);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  logic [ROW_W-1:0] init_row;
  logic [WIDTH-1:0] default_row;

  logic [WIDTH-1:0] storage [GAME_HEIGHT];

  // Write FIFO: entries are {x, y, wall} held in parallel arrays.
  logic [5:0]       q_x    [WQ_DEPTH];
  logic [5:0]       q_y    [WQ_DEPTH];
  logic             q_wall [WQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic       running;
  logic       full;
  logic       push;
  logic       pop;
  logic [5:0] pop_x;
  logic [5:0] pop_y;
  logic       pop_wall;
  logic       pop_in_range;

  logic request_in_range;
  logic query_in_range;
  logic request_bit;
  logic query_bit;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    running     = 1'b0;
    full        = 1'b0;
    o_init_done = 1'b0;
    o_wr_ready  = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;

    case (state)
      INIT: begin
        if (init_row == LAST_ROW) begin
          next_state = RUN;
        end
      end
      RUN: begin
        running = 1'b1;
      end
      default: begin
        next_state = INIT;
      end
    endcase

    // A clear pulse wins over everything: it restarts loading and throws
    // away any write that would have been accepted or drained this cycle.
    if (i_clear) begin
      next_state = INIT;
    end

    full        = (count == FULL_COUNT);
    o_init_done = running;
    o_wr_ready  = running && !full;
    push        = i_wr_valid && o_wr_ready && !i_clear;
    pop         = running && !i_buzy && (count != '0) && !i_clear;
  end

  // --------------------------------------------------------------------------
  // Default map loader
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_row <= '0;
    end else if (i_clear) begin
      init_row <= '0;
    end else if (state == INIT) begin
      init_row <= (init_row == LAST_ROW) ? '0 : init_row + ROW_ONE;
    end
  end

  // Top and bottom rows are solid; every other row only has its two edge
  // columns set, giving a closed border around an empty playfield.
  always_comb begin
    default_row            = '0;
    default_row[0]         = 1'b1;
    default_row[WIDTH-1]   = 1'b1;
    if ((init_row == '0) || (init_row == LAST_ROW)) begin
      default_row = '1;
    end
  end

  // --------------------------------------------------------------------------
  // Write FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset: the pointers and count decide validity.
  always_ff @(posedge clk) begin
    if (push) begin
      q_x[wr_ptr]    <= i_wr_x;
      q_y[wr_ptr]    <= i_wr_y;
      q_wall[wr_ptr] <= i_wr_wall;
    end
  end

  assign pop_x        = q_x[rd_ptr];
  assign pop_y        = q_y[rd_ptr];
  assign pop_wall     = q_wall[rd_ptr];
  assign pop_in_range = ({1'b0, pop_y} < ROW_LIMIT) && ({1'b0, pop_x} < COL_LIMIT);

  // --------------------------------------------------------------------------
  // Storage: loader owns it during INIT, FIFO drain owns it during RUN.
  // Contents are left alone by rst because INIT rewrites every row.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if ((state == INIT) && !i_clear) begin
      storage[init_row] <= default_row;
    end else if (pop && pop_in_range) begin
      storage[pop_y[ROW_W-1:0]][pop_x[COL_W-1:0]] <= pop_wall;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports. Reads sample storage before this edge's drain lands, so a
  // same-cycle read of the cell being written returns the old value.
  // Anything outside the grid, or any read while loading, reports wall.
  // --------------------------------------------------------------------------
  assign request_in_range = ({1'b0, i_request_y} < ROW_LIMIT) && ({1'b0, i_request_x} < COL_LIMIT);
  assign query_in_range   = ({1'b0, i_query_y} < ROW_LIMIT) && ({1'b0, i_query_x} < COL_LIMIT);
  assign request_bit      = storage[i_request_y[ROW_W-1:0]][i_request_x[COL_W-1:0]];
  assign query_bit        = storage[i_query_y[ROW_W-1:0]][i_query_x[COL_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_is_wall    <= 1'b1;
      o_query_wall <= 1'b1;
    end else begin
      o_is_wall    <= (running && request_in_range) ? request_bit : 1'b1;
      o_query_wall <= (running && query_in_range) ? query_bit : 1'b1;
    end
  end

endmodule
`default_nettype wire
